cp0_exc_unit: RTL and testbench
===============================

Name: cp0_exc_unit

Overview:
- Coprocessor-0 exception/interrupt unit for the P7 five-stage MIPS core. It sits at the M stage and consumes the exception codes raised upstream, including the ALU arithmetic-overflow flag (ExcCode 12) and the DM address-overflow flag (mapped to AdEL/AdES).
- It holds SR, Cause and EPC, and decides when a trap is taken.
- It drives the flush/redirect request and supplies EPC for ERET.

Parameters:
- HANDLER_PC, 32'h0000_4180, exception entry vector driven on handler_pc.
- IM_W, 6, number of hardware interrupt lines (IM/IP width).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pc_m  input  32  PC of the M-stage instruction; word-aligned.
- bd_m  input  1  M-stage instruction is in a delay slot.
- exc_code_m  input  5  pipelined exception code; 0 means no exception.
- hw_int  input  IM_W  level-sensitive external interrupt lines.
- we  input  1  MTC0 write enable.
- addr  input  5  CP0 register number for MTC0/MFC0.
- wdata  input  32  MTC0 write data.
- eret  input  1  ERET in M stage.
- rdata  output  32  MFC0 read data (combinational).
- epc_out  output  32  current EPC; forwarded to ERET redirect.
- handler_pc  output  32  constant HANDLER_PC.
- req  output  1  take trap this cycle; flush pipeline and redirect to handler_pc.

Behaviour:
- Reset (async, rst_n=0): SR, Cause and EPC all 0, so req=0, rdata=0 and epc_out=0.
- Register map:
  - 12 = SR: IM[15:10], EXL[1], IE[0]; other bits read 0.
  - 13 = Cause: BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - 14 = EPC.
  - Any other addr reads 0.
- Combinational terms:
  - int_req = IE & ~EXL & |(hw_int & IM).
  - exc_req = (exc_code_m != 0) & ~EXL.
  - req = int_req | exc_req. Interrupt wins over a synchronous exception.
- Every cycle (including trap cycles): Cause.IP <= hw_int. IP is a sampled copy and lags hw_int by one cycle; req uses live hw_int.
- On req, at the edge:
  - EXL <= 1.
  - ExcCode <= (int_req ? 0 : exc_code_m).
  - BD <= bd_m.
  - EPC <= bd_m ? pc_m - 4 : pc_m.
- eret without req: EXL <= 0 at the edge. epc_out already holds the return target combinationally in the eret cycle.
- MTC0 (we & ~req):
  - SR writes only IM/EXL/IE from wdata; other bits stay 0.
  - EPC writes wdata[31:2] with bits [1:0] forced to 0.
  - Writes to Cause are ignored; Cause is read-only.
- Simultaneous events:
  - req & we: the write is dropped, because the trapping instruction must not commit.
  - req & eret: the trap wins and EXL stays 1.
  - eret & we to SR: the write is applied, then EXL is cleared (eret dominates the EXL bit).
- rdata reflects the register value before the current edge; there is no internal bypass. Forwarding of a just-written CP0 value is the hazard unit's job.
- Nested traps: with EXL=1, all exceptions and interrupts are masked. EPC, BD and ExcCode are preserved until eret.
- rst_n asserted mid-trap: state clears immediately and req drops in the same cycle.

Decomposition:
- Shared Defines package additions:
  - CP0 register numbers: `CP0_SR 12, `CP0_CAUSE 13, `CP0_EPC 14.
  - ExcCode constants: `EXC_INT 0, `EXC_ADEL 4, `EXC_ADES 5, `EXC_SYSCALL 8, `EXC_RI 10, `EXC_OV 12.
  - SR/Cause field bit positions.
- No sub-module is needed. The block is a single register file plus trap logic. Mapping ALU Exc_Ov/Exc_Ov_DM to exc_code_m is done in the M-stage pipeline register, not here.

Test Plan:
- Reset, then read addr 12/13/14 → rdata = 0 for each; req = 0.
- MTC0 SR wdata=32'hFFFF_FFFF → SR reads 32'h0000_FC03. Then exc_code_m=12, pc_m=32'h3010, bd_m=0 → req=1. After the edge: EPC=32'h3010, Cause=32'h0000_0030, EXL=1.
- exc_code_m=12, pc_m=32'h3024, bd_m=1 → EPC=32'h3020 and Cause[31]=1. A second exc_code_m=10 while EXL=1 → req=0 and EPC is unchanged.
- SR=32'h0000_0401 (IM[10], IE), hw_int=6'b000001, exc_code_m=12 in the same cycle → req=1 and ExcCode=0 (interrupt priority). One cycle later Cause.IP reads 6'b000001.
- req and we (EPC, wdata=32'h1234_5678) in the same cycle → EPC = trapping pc_m, not the written value. A later standalone MTC0 EPC with 32'h1234_567B → EPC reads 32'h1234_5678.
- EXL=1, eret=1 → epc_out equals EPC in that cycle, EXL=0 after the edge. A pending enabled hw_int then asserts req on the following cycle.

Source files
------------

// File: rtl/cp0_exc_unit_pkg.sv
// CP0 register numbers, exception codes and SR/Cause field positions shared by
// the M-stage trap logic and the pipeline registers that feed it.
package cp0_exc_unit_pkg;

  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_BD_BIT  = 31;

  typedef enum logic [1:0] {
    TRAP_NONE = 2'd0,
    TRAP_INT  = 2'd1,
    TRAP_EXC  = 2'd2
  } trap_kind_e;

  // A delay-slot instruction returns to its branch so the branch re-executes.
  function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic bd);
    return bd ? (pc - 32'd4) : pc;
  endfunction

endpackage

// File: rtl/cp0_exc_unit.sv
// M-stage CP0: SR/Cause/EPC register file, trap decision and ERET support.
// req/rdata/epc_out are combinational from current state; all updates land on the next edge.
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter int          IM_W       = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     pc_m,
  input  logic            bd_m,
  input  logic [4:0]      exc_code_m,
  input  logic [IM_W-1:0] hw_int,
  input  logic            we,
  input  logic [4:0]      addr,
  input  logic [31:0]     wdata,
  input  logic            eret,
  output logic [31:0]     rdata,
  output logic [31:0]     epc_out,
  output logic [31:0]     handler_pc,
  output logic            req
);

  logic [IM_W-1:0] im_q, im_d;
  logic [IM_W-1:0] ip_q, ip_d;
  logic            ie_q, ie_d;
  logic            exl_q, exl_d;
  logic            bd_q, bd_d;
  logic [4:0]      exc_code_q, exc_code_d;
  logic [31:0]     epc_q, epc_d;

  logic            int_req;
  logic            exc_req;
  trap_kind_e      trap_kind;
  logic [31:0]     sr_rd;
  logic [31:0]     cause_rd;

  assign int_req = ie_q & ~exl_q & (|(hw_int & im_q));
  assign exc_req = (exc_code_m != EXC_INT) & ~exl_q;

  // Gating with rst_n keeps req low while reset is held even if an upstream
  // exception code is still present.
  always_comb begin
    trap_kind = TRAP_NONE;
    if (rst_n) begin
      if (int_req) begin
        trap_kind = TRAP_INT;
      end else if (exc_req) begin
        trap_kind = TRAP_EXC;
      end
    end
  end

  assign req        = (trap_kind != TRAP_NONE);
  assign epc_out    = epc_q;
  assign handler_pc = HANDLER_PC;

  always_comb begin
    sr_rd                              = '0;
    sr_rd[SR_IM_LSB +: IM_W]           = im_q;
    sr_rd[SR_EXL_BIT]                  = exl_q;
    sr_rd[SR_IE_BIT]                   = ie_q;
    cause_rd                           = '0;
    cause_rd[CAUSE_BD_BIT]             = bd_q;
    cause_rd[CAUSE_IP_LSB +: IM_W]     = ip_q;
    cause_rd[CAUSE_EXC_LSB +: 5]       = exc_code_q;
    case (addr)
      CP0_SR:    rdata = sr_rd;
      CP0_CAUSE: rdata = cause_rd;
      CP0_EPC:   rdata = epc_q;
      default:   rdata = '0;
    endcase
  end

  always_comb begin
    im_d       = im_q;
    ie_d       = ie_q;
    exl_d      = exl_q;
    bd_d       = bd_q;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    ip_d       = hw_int;
    if (req) begin
      // The trapping instruction must not commit, so any MTC0 or ERET is dropped.
      exl_d      = 1'b1;
      exc_code_d = (trap_kind == TRAP_INT) ? EXC_INT : exc_code_m;
      bd_d       = bd_m;
      epc_d      = epc_target(pc_m, bd_m);
    end else begin
      if (we && (addr == CP0_SR)) begin
        im_d  = wdata[SR_IM_LSB +: IM_W];
        exl_d = wdata[SR_EXL_BIT];
        ie_d  = wdata[SR_IE_BIT];
      end
      if (we && (addr == CP0_EPC)) begin
        epc_d = {wdata[31:2], 2'b00};
      end
      if (eret) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      im_q       <= '0;
      ip_q       <= '0;
      ie_q       <= 1'b0;
      exl_q      <= 1'b0;
      bd_q       <= 1'b0;
      exc_code_q <= EXC_INT;
      epc_q      <= '0;
    end else begin
      im_q       <= im_d;
      ip_q       <= ip_d;
      ie_q       <= ie_d;
      exl_q      <= exl_d;
      bd_q       <= bd_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// Directed and randomized check of cp0_exc_unit against a register-image model.
module tb_cp0_exc_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code_m;
  logic [5:0]  hw_int;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic        eret;
  logic [31:0] rdata;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;
  logic        req;

  int n_chk  = 0;
  int n_fail = 0;

  // Model holds the architecturally visible 32-bit register images.
  logic [31:0] m_sr, m_cause, m_epc;

  cp0_exc_unit #(.HANDLER_PC(32'h0000_4180), .IM_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .pc_m(pc_m), .bd_m(bd_m), .exc_code_m(exc_code_m),
    .hw_int(hw_int), .we(we), .addr(addr), .wdata(wdata), .eret(eret),
    .rdata(rdata), .epc_out(epc_out), .handler_pc(handler_pc), .req(req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit model_int();
    logic [5:0] im;
    im = m_sr[15:10];
    return m_sr[0] && !m_sr[1] && ((hw_int & im) != 6'd0);
  endfunction

  function automatic bit model_req();
    return (rst_n === 1'b1) && (model_int() || ((exc_code_m != 5'd0) && !m_sr[1]));
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    if (a == 5'd12) return m_sr;
    if (a == 5'd13) return m_cause;
    if (a == 5'd14) return m_epc;
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
  endtask

  // Inputs are already applied; check outputs, advance model and DUT by one edge.
  task automatic tick();
    logic [31:0] sr_n, cause_n, epc_n;
    bit ir, tr;
    #1;
    ir = model_int();
    tr = model_req();
    check("req", {31'd0, req}, {31'd0, tr});
    check("rdata", rdata, model_rd(addr));
    check("epc_out", epc_out, m_epc);
    sr_n = m_sr; cause_n = m_cause; epc_n = m_epc;
    cause_n[15:10] = hw_int;
    if (tr) begin
      sr_n[1]        = 1'b1;
      cause_n[6:2]   = ir ? 5'd0 : exc_code_m;
      cause_n[31]    = bd_m;
      epc_n          = bd_m ? pc_m - 32'd4 : pc_m;
    end else begin
      if (we && addr == 5'd12) sr_n = wdata & 32'h0000_FC03;
      if (we && addr == 5'd14) epc_n = wdata & 32'hFFFF_FFFC;
      if (eret) sr_n[1] = 1'b0;
    end
    @(posedge clk);
    m_sr = sr_n; m_cause = cause_n; m_epc = epc_n;
    #1;
  endtask

  task automatic idle();
    we = 1'b0; eret = 1'b0; exc_code_m = 5'd0; bd_m = 1'b0; wdata = 32'd0;
  endtask

  task automatic peek(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    idle(); we = 1'b1; addr = a; wdata = d; tick();
  endtask

  task automatic do_eret();
    idle(); eret = 1'b1; tick();
  endtask

  task automatic raise(input logic [4:0] code, input logic [31:0] pc, input logic bd);
    idle(); exc_code_m = code; pc_m = pc; bd_m = bd; tick();
  endtask

  logic [4:0] codes [5] = '{5'd4, 5'd5, 5'd8, 5'd10, 5'd12};

  initial begin
    logic [31:0] r;
    rst_n = 1'b0; pc_m = 32'd0; hw_int = 6'd0; addr = 5'd0;
    idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    peek("rst_sr", 5'd12, 32'd0);
    peek("rst_cause", 5'd13, 32'd0);
    peek("rst_epc", 5'd14, 32'd0);
    check("rst_req", {31'd0, req}, 32'd0);
    check("handler_pc", handler_pc, 32'h0000_4180);

    mtc0(5'd12, 32'hFFFF_FFFF);
    peek("sr_write_mask", 5'd12, 32'h0000_FC03);
    // The all-ones write set EXL, which masks traps until ERET.
    idle(); exc_code_m = 5'd12; pc_m = 32'h3000; #1;
    check("exl_masks_exc", {31'd0, req}, 32'd0);
    do_eret();
    peek("eret_clears_exl", 5'd12, 32'h0000_FC01);

    idle(); exc_code_m = 5'd12; pc_m = 32'h3010; #1;
    check("ov_req", {31'd0, req}, 32'd1);
    tick();
    peek("ov_epc", 5'd14, 32'h0000_3010);
    peek("ov_cause", 5'd13, 32'h0000_0030);
    peek("ov_sr_exl", 5'd12, 32'h0000_FC03);

    do_eret();
    raise(5'd12, 32'h3024, 1'b1);
    peek("bd_epc", 5'd14, 32'h0000_3020);
    peek("bd_cause", 5'd13, 32'h8000_0030);
    idle(); exc_code_m = 5'd10; pc_m = 32'h3028; #1;
    check("nested_masked", {31'd0, req}, 32'd0);
    tick();
    peek("nested_epc", 5'd14, 32'h0000_3020);

    do_eret();
    mtc0(5'd12, 32'h0000_0401);
    idle(); hw_int = 6'b000001; exc_code_m = 5'd12; pc_m = 32'h3040; #1;
    check("int_prio_req", {31'd0, req}, 32'd1);
    tick();
    peek("int_prio_cause", 5'd13, 32'h0000_0400);

    idle(); eret = 1'b1; #1;
    check("eret_epc_out", epc_out, 32'h0000_3040);
    tick();
    idle(); pc_m = 32'h3050; #1;
    check("pending_int_req", {31'd0, req}, 32'd1);
    tick();
    hw_int = 6'd0;
    do_eret();

    idle(); exc_code_m = 5'd12; pc_m = 32'h3060; we = 1'b1; addr = 5'd14; wdata = 32'h1234_5678;
    tick();
    peek("trap_drops_mtc0", 5'd14, 32'h0000_3060);
    do_eret();
    mtc0(5'd14, 32'h1234_567B);
    peek("epc_align", 5'd14, 32'h1234_5678);

    idle(); we = 1'b1; addr = 5'd12; wdata = 32'h0000_FC03; eret = 1'b1;
    tick();
    peek("eret_beats_sr_exl", 5'd12, 32'h0000_FC01);

    raise(5'd4, 32'h3070, 1'b0);
    idle(); exc_code_m = 5'd12; rst_n = 1'b0; model_reset(); #1;
    check("async_rst_req", {31'd0, req}, 32'd0);
    peek("async_rst_sr", 5'd12, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idle();

    for (int i = 0; i < 1500; i++) begin
      idle();
      if ($urandom_range(0, 3) == 0) exc_code_m = codes[$urandom_range(0, 4)];
      hw_int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      we     = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 3))
        0:       addr = 5'd12;
        1:       addr = 5'd13;
        2:       addr = 5'd14;
        default: addr = 5'($urandom);
      endcase
      r = $urandom;
      wdata = r;
      eret  = ($urandom_range(0, 5) == 0);
      r = $urandom;
      pc_m  = r & 32'hFFFF_FFFC;
      bd_m  = 1'($urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
